// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: SINGLE/INCR4/INCR8/INCR16 incrementing bursts with
// address/data phase pipelining, unlimited slave wait states and two-cycle
// ERROR response handling. One burst in flight at a time.
module ahb_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  start,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            len,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  hreadyout,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata,
  output logic [SEL_W-1:0]      sel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [1:0]            htrans,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int HSIZE_V = $clog2(BYTES);

  // ADDR:  first NONSEQ on the bus, no data phase yet
  // BURST: SEQ address phase overlapping the previous beat's data phase
  // LAST:  bus idle, final data phase outstanding
  // ERR:   first ERROR cycle seen, waiting for the second one
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [3:0]            beats_m1;
  logic [3:0]            beat_cnt;
  logic [3:0]            start_beats_m1;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  misaligned;
  logic                  start_ok;
  logic                  start_rej;
  logic                  last_addr;
  logic                  addr_acc;
  logic                  beat_ok;
  logic                  fin_ok;
  logic                  fin_err;

  assign hsize     = 3'(HSIZE_V);
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;
  assign busy      = (state != S_IDLE);
  assign last_addr = (beat_cnt == beats_m1);

  // Burst length decode and alignment check of a new request; a burst of at
  // most 128 bytes aligned to its own size can never cross a 1KB boundary
  always_comb begin
    start_beats_m1 = 4'd0;
    case (len)
      2'b00:   start_beats_m1 = 4'd0;
      2'b01:   start_beats_m1 = 4'd3;
      2'b10:   start_beats_m1 = 4'd7;
      default: start_beats_m1 = 4'd15;
    endcase
    burst_bytes = (ADDR_WIDTH'(start_beats_m1) + ADDR_WIDTH'(1)) << HSIZE_V;
    misaligned  = |(addr & (burst_bytes - ADDR_WIDTH'(1)));
    start_ok    = (state == S_IDLE) && start && !misaligned;
    start_rej   = (state == S_IDLE) && start && misaligned;
  end

  // Transfer type is a pure decode of the state so a reset forces IDLE at once
  always_comb begin
    case (state)
      S_ADDR:  htrans = 2'b10;
      S_BURST: htrans = 2'b11;
      default: htrans = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-edge events (address accepted, beat completed, end)
  always_comb begin
    state_nxt = state;
    addr_acc  = 1'b0;
    beat_ok   = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (hreadyout) begin
          addr_acc  = 1'b1;
          state_nxt = last_addr ? S_LAST : S_BURST;
        end
      end
      S_BURST: begin
        if (hresp) begin
          if (hreadyout) begin
            fin_err   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ERR;
          end
        end else if (hreadyout) begin
          beat_ok   = 1'b1;
          addr_acc  = 1'b1;
          state_nxt = last_addr ? S_LAST : S_BURST;
        end
      end
      S_LAST: begin
        if (hresp) begin
          if (hreadyout) begin
            fin_err   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ERR;
          end
        end else if (hreadyout) begin
          beat_ok   = 1'b1;
          fin_ok    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (hreadyout) begin
          fin_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/control latching, beat counting, write/read data and status pulses
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      haddr      <= '0;
      hwrite     <= 1'b0;
      hburst     <= '0;
      sel        <= '0;
      hwdata     <= '0;
      dout       <= '0;
      beats_m1   <= '0;
      beat_cnt   <= '0;
      wdata_ack  <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done       <= fin_ok | fin_err | start_rej;
      err        <= fin_err | start_rej;
      wdata_ack  <= addr_acc & hwrite;
      dout_valid <= beat_ok & ~hwrite;
      if (start_ok) begin
        haddr    <= addr;
        hwrite   <= wr;
        hburst   <= {len, |len};
        sel      <= slave_sel;
        beats_m1 <= start_beats_m1;
        beat_cnt <= '0;
      end else if (addr_acc) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (!last_addr) haddr <= haddr + ADDR_WIDTH'(BYTES);
      end
      if (addr_acc && hwrite) hwdata <= wdata;
      if (beat_ok && !hwrite) dout <= hrdata;
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master with a reactive slave model and
// scoreboard queues for addresses, read data and burst completion status.
module tb_ahb_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int SW = 2;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          start = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    len = '0;
  logic [SW-1:0] slave_sel = '0;
  logic [DW-1:0] wdata = '0;
  logic          hreadyout = 1'b1;
  logic          hresp = 1'b0;
  logic [DW-1:0] hrdata = '0;
  logic [SW-1:0] sel;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hmastlock;
  logic [DW-1:0] hwdata;
  logic          wdata_ack;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;
  logic          err;

  ahb_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS)) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .wr(wr), .addr(addr),
    .len(len), .slave_sel(slave_sel), .wdata(wdata), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .sel(sel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hwdata(hwdata), .wdata_ack(wdata_ack),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int dv_cnt = 0;
  int abeat = 0;
  int dp_beat = 0;
  int wait_beat = -1;
  int wait_left = 0;
  int err_beat = -1;
  int d0 = 0;
  bit dp_act = 1'b0;
  bit dp_wr = 1'b0;
  bit err_phase = 1'b0;
  logic [31:0]   wbase = '0;
  logic [2:0]    exp_burst = '0;
  logic          exp_wr = 1'b0;
  logic [SW-1:0] exp_sel = '0;

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] rd_q[$];
  bit            done_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: observe the DUT at the falling edge, then drive the slave
  // response that the next rising edge will sample.
  task automatic step();
    @(negedge hclk);
    cyc++;
    start = 1'b0;
    if (dout_valid) begin
      dv_cnt++;
      chk("dout_valid_expected", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) chk("dout", 64'(dout), 64'(rd_q.pop_front()));
    end
    if (wdata_ack) begin
      ack_cnt++;
      wdata = wbase + 32'(ack_cnt);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_expected", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) chk("err", 64'(err), 64'(done_q.pop_front()));
      chk("busy_with_done", 64'(busy), 64'd0);
    end
    hreadyout = 1'b1;
    hresp = 1'b0;
    if (dp_act) begin
      if (dp_beat == err_beat) begin
        hresp = 1'b1;
        if (err_phase) chk("htrans_after_err", 64'(htrans), 64'd0);
        else hreadyout = 1'b0;
        err_phase = 1'b1;
      end else if (dp_beat == wait_beat && wait_left > 0) begin
        hreadyout = 1'b0;
        wait_left--;
      end else if (dp_wr) begin
        chk("hwdata", 64'(hwdata), 64'(wbase + 32'(dp_beat)));
      end else begin
        hrdata = 32'hA0 + 32'(dp_beat);
        rd_q.push_back(hrdata);
      end
    end
    if (htrans[1]) begin
      chk("addr_expected", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) begin
        if (!hreadyout) chk("haddr_hold", 64'(haddr), 64'(addr_q[0]));
        else begin
          chk("haddr", 64'(haddr), 64'(addr_q[0]));
          chk("htrans", 64'(htrans), (abeat == 0) ? 64'd2 : 64'd3);
          if (abeat == 0) begin
            chk("hburst", 64'(hburst), 64'(exp_burst));
            chk("hwrite", 64'(hwrite), 64'(exp_wr));
            chk("sel", 64'(sel), 64'(exp_sel));
            chk("busy", 64'(busy), 64'd1);
          end
          void'(addr_q.pop_front());
          dp_beat = abeat;
          abeat++;
        end
      end
    end
    if (hreadyout) dp_act = htrans[1];
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] l,
                       input logic [31:0] wb, input bit exp_err);
    int beats;
    beats = (l == 2'd0) ? 1 : (2 << l);
    case (l)
      2'd0:    exp_burst = 3'b000;
      2'd1:    exp_burst = 3'b011;
      2'd2:    exp_burst = 3'b101;
      default: exp_burst = 3'b111;
    endcase
    wbase = wb;
    wdata = wb;
    ack_cnt = 0;
    dv_cnt = 0;
    abeat = 0;
    err_phase = 1'b0;
    dp_wr = w;
    exp_wr = w;
    exp_sel = SW'(cyc + 1);
    slave_sel = exp_sel;
    wr = w;
    addr = a;
    len = l;
    start = 1'b1;
    start_cyc = cyc;
    if ((a % (beats * 4)) != 0) done_q.push_back(1'b1);
    else begin
      for (int k = 0; k < beats; k++) addr_q.push_back(a + 32'(4 * k));
      done_q.push_back(exp_err);
    end
  endtask

  task automatic wait_done(input int budget);
    int d;
    d = done_cnt;
    for (int i = 0; i < budget && done_cnt == d; i++) step();
    chk("burst_completes", 64'(done_cnt != d), 64'd1);
  endtask

  initial begin
    hreset = 1'b1;
    step();
    step();
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_hwdata", 64'(hwdata), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_wdata_ack", 64'(wdata_ack), 64'd0);
    chk("rst_hburst", 64'(hburst), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("hsize", 64'(hsize), 64'd2);
    chk("hprot", 64'(hprot), 64'd3);
    chk("hmastlock", 64'(hmastlock), 64'd0);
    hreset = 1'b0;
    step();

    // Write INCR4 at 0x40, data 1..4, no wait states
    issue(1'b1, 32'h40, 2'd1, 32'd1, 1'b0);
    wait_done(50);
    chk("t1_latency", 64'(done_cyc - start_cyc), 64'd6);
    chk("t1_acks", 64'(ack_cnt), 64'd4);
    chk("t1_addr_left", 64'(addr_q.size()), 64'd0);
    step();

    // Read INCR8 at 0x100 with two wait states on the third beat
    wait_beat = 2;
    wait_left = 2;
    issue(1'b0, 32'h100, 2'd2, 32'd0, 1'b0);
    wait_done(60);
    chk("t2_reads", 64'(dv_cnt), 64'd8);
    chk("t2_latency", 64'(done_cyc - start_cyc), 64'd12);
    chk("t2_addr_left", 64'(addr_q.size()), 64'd0);
    wait_beat = -1;
    step();

    // Write INCR16 at 0x0 with ERROR on the fifth beat
    err_beat = 4;
    issue(1'b1, 32'h0, 2'd3, 32'h1000, 1'b1);
    wait_done(60);
    chk("t3_acks", 64'(ack_cnt), 64'd5);
    err_beat = -1;
    addr_q.delete();
    step();

    // INCR4 at 0x3F8 is misaligned and would cross 1KB: rejected
    d0 = done_cnt;
    issue(1'b0, 32'h3F8, 2'd1, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_busy", 64'(busy), 64'd0);
    end
    chk("t4_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t4_done_latency", 64'(done_cyc - start_cyc), 64'd1);

    // Reset in the middle of an INCR8 read, then a SINGLE read
    issue(1'b0, 32'h200, 2'd2, 32'd0, 1'b0);
    for (int i = 0; i < 40 && abeat < 2; i++) step();
    chk("t5_reached_beat2", 64'(abeat >= 2), 64'd1);
    hreset = 1'b1;
    #1;
    chk("t5_rst_htrans", 64'(htrans), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    step();
    step();
    addr_q.delete();
    rd_q.delete();
    done_q.delete();
    dp_act = 1'b0;
    hreset = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    issue(1'b0, 32'h8, 2'd0, 32'd0, 1'b0);
    wait_done(20);
    chk("t5_single_reads", 64'(dv_cnt), 64'd1);
    chk("t5_latency", 64'(done_cyc - start_cyc), 64'd3);
    step();

    // Start pulses while a SINGLE write is busy are ignored
    d0 = done_cnt;
    issue(1'b1, 32'h10, 2'd0, 32'h55, 1'b0);
    step();
    start = 1'b1;
    addr = 32'h20;
    step();
    start = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t6_acks", 64'(ack_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
